lsu_stage: RTL and testbench

- Load/store unit in the MEM stage, directly downstream of the integer ALU.
- Takes the ALU-computed effective address, the RV32I load/store funct3 and the rs2 store data.
- Issues one aligned word access to data memory with byte strobes.
- Returns a sign- or zero-extended load result and raises a pipeline stall while the access is outstanding.
- Memory latency is variable (≥1 cycle); one request is in flight at a time.

---
 rtl/lsu_stage.sv | 216 +++++++++++++++++++++
 tb/tb_lsu_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage.sv
// lsu_stage: MEM-stage load/store unit.
//
// Takes the ALU effective address, RV32I load/store funct3 and rs2 store data, issues a
// single aligned word access with byte strobes, and returns the extended load result.
// One request is in flight at a time. The memory latency can be any number of cycles.
//
// Ports:
//   clk, rst           core clock (rising edge), asynchronous active-high reset
//   req_valid          MEM-stage op is a load/store; held until resp_valid
//   req_is_store       1 = store, 0 = load
//   req_funct3         000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr           effective address
//   req_wdata          store data (rs2)
//   req_ready          unit idle
//   mem_req            memory request, held until mem_ack
//   mem_we             write enable
//   mem_addr           word-aligned address
//   mem_wstrb          byte write strobes
//   mem_wdata          lane-replicated store data
//   mem_rdata          read data, valid with mem_ack
//   mem_ack            access complete (one-cycle pulse)
//   resp_valid         one-cycle completion pulse
//   resp_rdata         extended load data (0 for stores and faults)
//   resp_fault         misaligned or illegal funct3, qualified by resp_valid
//   stall              req_valid & ~resp_valid

module lsu_stage #(
    parameter int unsigned XLEN = 32  // only 32 is supported
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            req_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic            stall
);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              resp_fault_q, resp_fault_d;

    // Request decode: fault detection, strobes and replicated store data.
    logic              req_fault;
    logic [3:0]        req_wstrb;
    logic [XLEN-1:0]   req_wdata_rep;

    always_comb begin
        req_fault = 1'b0;
        unique case (req_funct3)
            3'b000, 3'b100: req_fault = 1'b0;
            3'b001, 3'b101: req_fault = req_addr[0];
            3'b010:         req_fault = (req_addr[1:0] != 2'b00);
            default:        req_fault = 1'b1;
        endcase
        // Stores only have signed-width encodings.
        if (req_is_store && req_funct3[2]) begin
            req_fault = 1'b1;
        end
    end

    always_comb begin
        req_wstrb     = 4'b0000;
        req_wdata_rep = req_wdata;
        if (req_is_store) begin
            unique case (req_funct3[1:0])
                2'b00: begin
                    req_wstrb     = 4'b0001 << req_addr[1:0];
                    req_wdata_rep = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    req_wstrb     = 4'b0011 << {req_addr[1], 1'b0};
                    req_wdata_rep = {2{req_wdata[15:0]}};
                end
                2'b10: begin
                    req_wstrb     = 4'b1111;
                    req_wdata_rep = req_wdata;
                end
                default: begin
                    req_wstrb     = 4'b0000;
                    req_wdata_rep = req_wdata;
                end
            endcase
        end
    end

    // Load extraction from the returned word at the latched byte offset.
    logic [XLEN-1:0] rdata_shift;
    logic [XLEN-1:0] load_data;

    always_comb begin
        rdata_shift = mem_rdata >> {off_q, 3'b000};
        unique case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){rdata_shift[7]}}, rdata_shift[7:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, rdata_shift[7:0]};
            3'b001:  load_data = {{(XLEN-16){rdata_shift[15]}}, rdata_shift[15:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, rdata_shift[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        off_d        = off_q;
        funct3_d     = funct3_q;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_fault) begin
                        resp_fault_d = 1'b1;
                        resp_rdata_d = '0;
                        state_d      = StResp;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_is_store;
                        mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
                        mem_wstrb_d = req_wstrb;
                        mem_wdata_d = req_wdata_rep;
                        off_d       = req_addr[1:0];
                        funct3_d    = req_funct3;
                        state_d     = StBusy;
                    end
                end
            end
            StBusy: begin
                if (mem_ack) begin
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_wstrb_d  = 4'b0000;
                    resp_fault_d = 1'b0;
                    // mem_we_q still holds the op type in this cycle.
                    resp_rdata_d = mem_we_q ? '0 : load_data;
                    state_d      = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= 4'b0000;
            mem_wdata_q  <= '0;
            off_q        <= 2'b00;
            funct3_q     <= 3'b000;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            off_q        <= off_d;
            funct3_q     <= funct3_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign stall      = req_valid & ~resp_valid;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage with a response scoreboard.
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        stall;

    lsu_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   resp_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Response monitor: every resp_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            exp_t e;
            resp_count++;
            total++;
            assert (sb.size() > 0)
            else begin
                bad++;
                $error("FAIL unexpected_resp: got rdata %h fault %b want none", resp_rdata,
                       resp_fault);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_fault", {31'b0, resp_fault}, {31'b0, e.fault});
            end
        end
    end

    // One operation from accept to the RESP cycle. Leaves req_valid high; the caller either
    // drops it or issues the next op in the cycle after RESP.
    task automatic do_op(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int ack_dly,
                         input logic [3:0] e_strb, input logic [31:0] e_wdata,
                         input logic [31:0] e_rdata, input logic e_fault);
        int t0;
        exp_t e;
        @(posedge clk);
        #1;
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wd;
        e.rdata      = e_rdata;
        e.fault      = e_fault;
        sb.push_back(e);
        t0 = cyc;
        @(negedge clk);
        chk({tag, "_ready_at_accept"}, {31'b0, req_ready}, 32'd1);
        chk({tag, "_stall_at_accept"}, {31'b0, stall}, 32'd1);
        if (e_fault) begin
            @(negedge clk);
            chk({tag, "_fault_no_memreq"}, {31'b0, mem_req}, 32'd0);
            chk({tag, "_fault_resp_valid"}, {31'b0, resp_valid}, 32'd1);
            chk({tag, "_fault_latency"}, cyc - t0, 32'd1);
        end else begin
            for (int k = 0; k <= ack_dly; k++) begin
                @(negedge clk);
                chk({tag, "_mem_req"}, {31'b0, mem_req}, 32'd1);
                chk({tag, "_stall_busy"}, {31'b0, stall}, 32'd1);
                if (k == 0) begin
                    chk({tag, "_mem_we"}, {31'b0, mem_we}, {31'b0, st});
                    chk({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                    chk({tag, "_mem_wstrb"}, {28'b0, mem_wstrb}, {28'b0, e_strb});
                    if (st) chk({tag, "_mem_wdata"}, mem_wdata, e_wdata);
                end
                if (k == ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end
            end
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            @(negedge clk);
            chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd1);
            chk({tag, "_latency"}, cyc - t0, ack_dly + 2);
            chk({tag, "_memreq_clr"}, {31'b0, mem_req}, 32'd0);
            chk({tag, "_wstrb_clr"}, {28'b0, mem_wstrb}, 32'd0);
        end
        chk({tag, "_stall_resp"}, {31'b0, stall}, 32'd0);
    endtask

    task automatic drop_req();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'b0, req_ready}, 32'd1);
        chk("idle_resp_valid", {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        int rc;
        // Reset values.
        #3;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // LB sign-extended, ack one cycle after mem_req.
        do_op("lb", 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0,
              4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0);
        drop_req();
        // LHU, ack delayed three cycles.
        do_op("lhu", 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 3,
              4'b0000, 32'h0, 32'h0000_BEEF, 1'b0);
        drop_req();
        // SB lane 1.
        do_op("sb", 1'b1, 3'b000, 32'h0000_0001, 32'h1234_56AB, 32'hDEAD_BEEF, 0,
              4'b0010, 32'hABAB_ABAB, 32'h0, 1'b0);
        drop_req();
        // SH upper half.
        do_op("sh", 1'b1, 3'b001, 32'h0000_0042, 32'hCAFE_5678, 32'h0, 1,
              4'b1100, 32'h5678_5678, 32'h0, 1'b0);
        drop_req();
        // LH sign-extended from lower half.
        do_op("lh", 1'b0, 3'b001, 32'h0000_0100, 32'h0, 32'h1234_8001, 0,
              4'b0000, 32'h0, 32'hFFFF_8001, 1'b0);
        drop_req();
        // LBU lane 2.
        do_op("lbu", 1'b0, 3'b100, 32'h0000_0202, 32'h0, 32'h00F7_0000, 0,
              4'b0000, 32'h0, 32'h0000_00F7, 1'b0);
        drop_req();
        // Faults: misaligned LW, illegal load funct3, illegal store funct3, misaligned SH.
        do_op("lw_mis", 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 0,
              4'b0000, 32'h0, 32'h0, 1'b1);
        drop_req();
        do_op("ld_011", 1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0,
              4'b0000, 32'h0, 32'h0, 1'b1);
        drop_req();
        do_op("st_100", 1'b1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 0,
              4'b0000, 32'h0, 32'h0, 1'b1);
        drop_req();
        do_op("sh_mis", 1'b1, 3'b001, 32'h0000_0003, 32'h0, 32'h0, 0,
              4'b0000, 32'h0, 32'h0, 1'b1);
        drop_req();

        // Reset asserted while BUSY; a later ack must not produce a response.
        @(posedge clk);
        #1;
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_funct3   = 3'b010;
        req_addr     = 32'h0000_0400;
        @(negedge clk);
        @(negedge clk);
        chk("rstbusy_mem_req_before", {31'b0, mem_req}, 32'd1);
        rc  = resp_count;
        rst = 1'b1;
        #1;
        chk("rstbusy_mem_req_async", {31'b0, mem_req}, 32'd0);
        chk("rstbusy_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstbusy_no_resp", resp_count, rc);
        chk("rstbusy_idle_ready", {31'b0, req_ready}, 32'd1);
        chk("rstbusy_idle_mem_req", {31'b0, mem_req}, 32'd0);

        // Spurious ack while idle.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("spur_ready", {31'b0, req_ready}, 32'd1);
        chk("spur_mem_req", {31'b0, mem_req}, 32'd0);
        chk("spur_no_resp", resp_count, rc);

        // Back-to-back SW then LW; second accept lands in the cycle after RESP.
        do_op("sw", 1'b1, 3'b010, 32'h0000_0800, 32'h89AB_CDEF, 32'h5555_5555, 0,
              4'b1111, 32'h89AB_CDEF, 32'h0, 1'b0);
        do_op("lw", 1'b0, 3'b010, 32'h0000_0804, 32'h0, 32'h89AB_CDEF, 1,
              4'b0000, 32'h0, 32'h89AB_CDEF, 1'b0);
        drop_req();

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
